// File: rtl/spi_pixel_receiver_if.sv
// rtl/spi_pixel_receiver_if.sv - frame buffer write port and status bundle
interface spi_pixel_receiver_if #(
    parameter int ADDR_W = 6
);
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [7:0]        wr_data_o;
    logic              frame_done_o;
    logic              busy_o;

    modport master (
        output wr_en_o,
        output wr_addr_o,
        output wr_data_o,
        output frame_done_o,
        output busy_o
    );

    modport slave (
        input wr_en_o,
        input wr_addr_o,
        input wr_data_o,
        input frame_done_o,
        input busy_o
    );
endinterface

// File: rtl/spi_pixel_receiver.sv
// rtl/spi_pixel_receiver.sv - oversampled SPI mode-0 slave writing pixel bytes into the frame buffer
module spi_pixel_receiver #(
    parameter int ADDR_W      = 6,
    parameter int DEPTH       = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck_i,
    input  logic                  mosi_i,
    input  logic                  cs_n_i,
    spi_pixel_receiver_if.master  fb
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                 state, next_state;
    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
    logic                   sck_s, mosi_s, cs_s;
    logic                   sck_prev, cs_prev;
    logic [SYNC_STAGES:0]   settle;
    logic                   armed;
    logic                   sck_rise, cs_fall, cs_rise;
    logic                   shift_en, byte_done;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_reg, rx_byte;
    logic [ADDR_W-1:0]      ptr;
    logic                   wrote_any;

    assign sck_s   = sck_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign rx_byte = {shift_reg[6:0], mosi_s};

    // A CS already low when reset releases must not open a transaction, so
    // cs_fall is only honoured once a settled high CS has been seen.
    assign sck_rise  = sck_s & ~sck_prev;
    assign cs_fall   = armed & cs_prev & ~cs_s;
    assign cs_rise   = cs_s & ~cs_prev;
    assign shift_en  = sck_rise & ~cs_s & (state != IDLE);
    assign byte_done = shift_en & (bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b1;
            settle    <= '0;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
            settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
            if (settle[SYNC_STAGES] && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (cs_fall) next_state = ADDR;
            ADDR: begin
                if (cs_rise)        next_state = IDLE;
                else if (byte_done) next_state = DATA;
            end
            DATA: if (cs_rise) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            shift_reg       <= '0;
            ptr             <= '0;
            wrote_any       <= 1'b0;
            fb.wr_en_o      <= 1'b0;
            fb.wr_addr_o    <= '0;
            fb.wr_data_o    <= '0;
            fb.frame_done_o <= 1'b0;
            fb.busy_o       <= 1'b0;
        end else begin
            state           <= next_state;
            fb.busy_o       <= (next_state != IDLE);
            fb.wr_en_o      <= 1'b0;
            fb.frame_done_o <= (state != IDLE) && cs_rise && wrote_any;

            // Partial bytes die here: the counter restarts on any entry to or stay in IDLE.
            if (state == IDLE || next_state == IDLE) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                shift_reg <= rx_byte;
                bit_cnt   <= (bit_cnt == 3'd7) ? 3'd0 : bit_cnt + 3'd1;
            end

            if (next_state == IDLE) begin
                wrote_any <= 1'b0;
            end

            if (byte_done && state == ADDR) begin
                ptr <= ({1'b0, rx_byte[ADDR_W-1:0]} >= (ADDR_W+1)'(DEPTH)) ? '0 : rx_byte[ADDR_W-1:0];
            end else if (byte_done && state == DATA) begin
                fb.wr_en_o   <= 1'b1;
                fb.wr_addr_o <= ptr;
                fb.wr_data_o <= rx_byte;
                wrote_any    <= 1'b1;
                ptr          <= (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_spi_pixel_receiver.sv
// tb/tb_spi_pixel_receiver.sv - scoreboard bench driving two receivers (DEPTH 64 and 48) from one SPI bus
module tb_spi_pixel_receiver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck = 1'b0;
    logic mosi = 1'b0;
    logic cs_n = 1'b1;

    always #5 clk = ~clk;

    spi_pixel_receiver_if #(.ADDR_W(6)) bus64 ();
    spi_pixel_receiver_if #(.ADDR_W(6)) bus48 ();

    spi_pixel_receiver #(.ADDR_W(6), .DEPTH(64), .SYNC_STAGES(2)) dut64 (
        .clk(clk), .rst_n(rst_n), .sck_i(sck), .mosi_i(mosi), .cs_n_i(cs_n), .fb(bus64)
    );
    spi_pixel_receiver #(.ADDR_W(6), .DEPTH(48), .SYNC_STAGES(2)) dut48 (
        .clk(clk), .rst_n(rst_n), .sck_i(sck), .mosi_i(mosi), .cs_n_i(cs_n), .fb(bus48)
    );

    int compared = 0;
    int mismatched = 0;
    int q64[$];
    int q48[$];
    int tx_data[8];
    int act64, act48;

    // Event encoding: write = addr*256 + data, frame_done = 65536.
    localparam int EV_FRAME = 65536;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus64.wr_en_o || bus64.frame_done_o) begin
                act64 = bus64.frame_done_o ? EV_FRAME : (int'(bus64.wr_addr_o) * 256 + int'(bus64.wr_data_o));
                if (q64.size() == 0) check("unexpected_ev64", act64, -1);
                else check("ev64", act64, q64.pop_front());
            end
            if (bus48.wr_en_o || bus48.frame_done_o) begin
                act48 = bus48.frame_done_o ? EV_FRAME : (int'(bus48.wr_addr_o) * 256 + int'(bus48.wr_data_o));
                if (q48.size() == 0) check("unexpected_ev48", act48, -1);
                else check("ev48", act48, q48.pop_front());
            end
        end
    end

    task automatic push_txn(input int addr, input int n, input bit frame);
        int a, p64, p48;
        a = addr % 64;
        p64 = a;
        p48 = (a >= 48) ? 0 : a;
        for (int k = 0; k < n; k++) begin
            q64.push_back(p64 * 256 + tx_data[k]);
            q48.push_back(p48 * 256 + tx_data[k]);
            p64 = (p64 + 1) % 64;
            p48 = (p48 + 1) % 48;
        end
        if (frame && n > 0) begin
            q64.push_back(EV_FRAME);
            q48.push_back(EV_FRAME);
        end
    endtask

    task automatic spi_bits(input int b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            mosi = ((b >> (7 - i)) & 1) != 0;
            repeat (3) @(negedge clk);
            sck = 1'b1;
            repeat (3) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && (q64.size() + q48.size()) != 0; i++) @(negedge clk);
        check(name, q64.size() + q48.size(), 0);
    endtask

    task automatic run_txn(input int addr, input int n, input int partial);
        push_txn(addr, n, 1'b1);
        cs_low();
        spi_bits(addr, 8);
        for (int k = 0; k < n; k++) spi_bits(tx_data[k], 8);
        if (partial > 0) spi_bits(int'($urandom_range(0, 255)), partial);
        cs_high();
        wait_drain("drain_txn");
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"}, int'(bus64.wr_en_o), 0);
        check({tag, "_wr_addr"}, int'(bus64.wr_addr_o), 0);
        check({tag, "_wr_data"}, int'(bus64.wr_data_o), 0);
        check({tag, "_frame_done"}, int'(bus64.frame_done_o), 0);
        check({tag, "_busy"}, int'(bus64.busy_o), 0);
        check({tag, "_busy48"}, int'(bus48.busy_o), 0);
        check({tag, "_wr_en48"}, int'(bus48.wr_en_o), 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_outputs_zero("in_reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_outputs_zero("after_reset");

        tx_data[0] = 8'hA5;
        run_txn(8'h05, 1, 0);

        tx_data[0] = 8'h11; tx_data[1] = 8'h22; tx_data[2] = 8'h33; tx_data[3] = 8'h44;
        run_txn(8'h3E, 4, 0);

        tx_data[0] = 8'h5A; tx_data[1] = 8'hC3;
        run_txn(8'h35, 2, 0);

        tx_data[0] = 8'hFF;
        run_txn(8'h00, 1, 5);

        // Address-only transaction: busy while CS low, nothing written.
        cs_low();
        check("busy_addr_only_start", int'(bus64.busy_o), 1);
        spi_bits(8'h10, 8);
        repeat (4) @(negedge clk);
        check("busy_addr_only_end", int'(bus64.busy_o), 1);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check("busy_after_cs_high", int'(bus64.busy_o), 0);
        wait_drain("drain_addr_only");

        run_txn(8'h21, 0, 0);

        for (int t = 0; t < 10; t++) begin
            int addr, n, partial;
            addr = int'($urandom_range(0, 255));
            n = int'($urandom_range(0, 5));
            partial = int'($urandom_range(0, 7));
            for (int k = 0; k < n; k++) tx_data[k] = int'($urandom_range(0, 255));
            run_txn(addr, n, partial);
        end

        // Reset in the middle of a transaction, with CS held low across release.
        tx_data[0] = 8'h91; tx_data[1] = 8'h92; tx_data[2] = 8'h93;
        push_txn(8'h2A, 3, 1'b0);
        cs_low();
        spi_bits(8'h2A, 8);
        for (int k = 0; k < 3; k++) spi_bits(tx_data[k], 8);
        repeat (4) @(negedge clk);
        wait_drain("drain_before_reset");
        check("busy_before_reset", int'(bus64.busy_o), 1);
        #3 rst_n = 1'b0;
        #1 check_outputs_zero("mid_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        spi_bits(8'h07, 8);
        spi_bits(8'hEE, 8);
        cs_high();
        check("busy_stale_cs", int'(bus64.busy_o), 0);
        wait_drain("drain_stale_cs");

        tx_data[0] = 8'h7E;
        run_txn(8'h02, 1, 0);

        repeat (10) @(negedge clk);
        check("final_queue64", q64.size(), 0);
        check("final_queue48", q48.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
